pulse_filter_multi: RTL

Parametrised multi-channel pulse-width qualifier, successor to the fixed 32-channel single-threshold filter. Each channel synchronises an asynchronous input, then propagates a level change to its output only after the new level has been stable for a programmable number of clocks. Rising and falling edges have separate thresholds, and channels can be bypassed individually. The block sits between raw external pulse pins and downstream event logic, and adds edge-event strobes and a saturating rejected-glitch counter for diagnostics.

---
 rtl/pulse_filter_pkg.sv | 31 +++
 rtl/pulse_filter_chan.sv | 133 +++++++++++++
 rtl/pulse_filter_multi.sv | 71 +++++++
 3 files changed

// File: rtl/pulse_filter_pkg.sv
// Shared types, width defaults and the saturating adder for the pulse filter.
// The adder is fixed at 32 bits so callers of any width up to 32 can use it.
package pulse_filter_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    RISE_Q = 2'd1,
    HIGH   = 2'd2,
    FALL_Q = 2'd3
  } pf_state_t;

  localparam int PF_CH_NUM_DEF      = 32;
  localparam int PF_CNT_W_DEF       = 22;
  localparam int PF_SYNC_STAGES_DEF = 2;
  localparam int PF_REJ_W_DEF       = 16;

  // Adds inc to acc and clamps the result at max_val.
  function automatic logic [31:0] pf_sat_add(
    input logic [31:0] acc,
    input logic [31:0] inc,
    input logic [31:0] max_val
  );
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/pulse_filter_chan.sv
// One filter channel: input synchroniser, qualification state machine and
// counter, registered level, edge strobes and the rejected-glitch strobe.
module pulse_filter_chan
  import pulse_filter_pkg::*;
#(
  parameter int CNT_W       = PF_CNT_W_DEF,
  parameter int SYNC_STAGES = PF_SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] thres_rise,
  input  logic [CNT_W-1:0] thres_fall,
  input  logic             bypass,
  output logic             pulse_out,
  output logic             rise_evt,
  output logic             fall_evt,
  output logic             rej_stb
);

  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  pf_state_t              state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [CNT_W:0]         run, need_rise, need_fall;
  logic                   pulse_out_reg, pulse_next;
  logic                   rise_evt_reg, fall_evt_reg;
  logic                   rej_stb_reg, rej_next;

  assign s = sync_reg[SYNC_STAGES-1];

  // A zero threshold is treated as one; cnt holds the number of samples of
  // the pending level seen so far, so run includes the current sample.
  assign need_rise = (thres_rise == '0) ? ONE : {1'b0, thres_rise};
  assign need_fall = (thres_fall == '0) ? ONE : {1'b0, thres_fall};
  assign run       = {1'b0, cnt_reg} + ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pulse_in};
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rej_next   = 1'b0;
    if (bypass) begin
      state_next = s ? HIGH : LOW;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        LOW: begin
          if (s) begin
            if (need_rise == ONE) begin
              state_next = HIGH;
            end else begin
              state_next = RISE_Q;
              cnt_next   = ONE[CNT_W-1:0];
            end
          end
        end
        RISE_Q: begin
          if (!s) begin
            state_next = LOW;
            cnt_next   = '0;
            rej_next   = 1'b1;
          end else if (run >= need_rise) begin
            state_next = HIGH;
            cnt_next   = '0;
          end else begin
            cnt_next = run[CNT_W-1:0];
          end
        end
        HIGH: begin
          if (!s) begin
            if (need_fall == ONE) begin
              state_next = LOW;
            end else begin
              state_next = FALL_Q;
              cnt_next   = ONE[CNT_W-1:0];
            end
          end
        end
        FALL_Q: begin
          // An aborted low glitch is not a diagnostic event.
          if (s) begin
            state_next = HIGH;
            cnt_next   = '0;
          end else if (run >= need_fall) begin
            state_next = LOW;
            cnt_next   = '0;
          end else begin
            cnt_next = run[CNT_W-1:0];
          end
        end
        default: begin
          state_next = LOW;
          cnt_next   = '0;
        end
      endcase
    end
    pulse_next = (state_next == HIGH) || (state_next == FALL_Q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= LOW;
      cnt_reg       <= '0;
      pulse_out_reg <= 1'b0;
      rise_evt_reg  <= 1'b0;
      fall_evt_reg  <= 1'b0;
      rej_stb_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pulse_out_reg <= pulse_next;
      rise_evt_reg  <= pulse_next & ~pulse_out_reg;
      fall_evt_reg  <= ~pulse_next & pulse_out_reg;
      rej_stb_reg   <= rej_next;
    end
  end

  assign pulse_out = pulse_out_reg;
  assign rise_evt  = rise_evt_reg;
  assign fall_evt  = fall_evt_reg;
  assign rej_stb   = rej_stb_reg;

endmodule

// File: rtl/pulse_filter_multi.sv
// Multi-channel pulse-width qualifier: an array of filter channels plus a
// saturating counter of rejected high glitches summed over all channels.
module pulse_filter_multi
  import pulse_filter_pkg::*;
#(
  parameter int CH_NUM      = PF_CH_NUM_DEF,
  parameter int CNT_W       = PF_CNT_W_DEF,
  parameter int SYNC_STAGES = PF_SYNC_STAGES_DEF,
  parameter int REJ_W       = PF_REJ_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] pulse_in,
  input  logic [CNT_W-1:0]  thres_rise,
  input  logic [CNT_W-1:0]  thres_fall,
  input  logic [CH_NUM-1:0] bypass,
  input  logic              rej_clr,
  output logic [CH_NUM-1:0] pulse_out,
  output logic [CH_NUM-1:0] rise_evt,
  output logic [CH_NUM-1:0] fall_evt,
  output logic [REJ_W-1:0]  rej_cnt
);

  localparam logic [31:0] REJ_MAX = 32'((64'd1 << REJ_W) - 64'd1);

  logic [CH_NUM-1:0] rej_stb;
  logic [31:0]       rej_pop;
  logic [REJ_W-1:0]  rej_cnt_reg, rej_cnt_next;

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_chan
      pulse_filter_chan #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in[gi]),
        .thres_rise(thres_rise),
        .thres_fall(thres_fall),
        .bypass    (bypass[gi]),
        .pulse_out (pulse_out[gi]),
        .rise_evt  (rise_evt[gi]),
        .fall_evt  (fall_evt[gi]),
        .rej_stb   (rej_stb[gi])
      );
    end
  endgenerate

  always_comb begin
    rej_pop = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      rej_pop = rej_pop + {31'b0, rej_stb[i]};
    end
    rej_cnt_next = REJ_W'(pf_sat_add(32'(rej_cnt_reg), rej_pop, REJ_MAX));
  end

  // Clear wins over any strobes arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rej_cnt_reg <= '0;
    end else if (rej_clr) begin
      rej_cnt_reg <= '0;
    end else begin
      rej_cnt_reg <= rej_cnt_next;
    end
  end

  assign rej_cnt = rej_cnt_reg;

endmodule
